uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver. Successor to the single-sample RX block.
- Runtime-configurable frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Samples each bit at its mid-point using an OS× sample tick.
- Buffers received frames, with per-frame error flags, in an internal FIFO.
- Sits between the pad-side rx line and the bus-side register/peripheral interface, which reads frames through a valid/ready handshake.

---
 rtl/uart_rx_os.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with runtime frame format
// (5..8 data bits, none/even/odd parity, 1 or 2 stop bits) and a receive FIFO
// that carries per-frame parity/framing error flags.
// Optional break detection is compiled in with `define UART_RX_BREAK_DET_EN.
module uart_rx_os #(
  parameter int OS         = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 32
) (
  input  logic                            clk,
  input  logic                            rstn_i,
  input  logic                            rx_enable_i,
  input  logic [DIV_W-1:0]                clk_div_i,
  input  logic [1:0]                      data_bits_i,
  input  logic                            parity_en_i,
  input  logic                            parity_odd_i,
  input  logic                            stop2_i,
  input  logic                            rx_i,
  output logic [7:0]                      rx_data_o,
  output logic                            rx_perr_o,
  output logic                            rx_ferr_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            rx_overrun_o,
  output logic                            rx_busy_o,
  output logic                            rx_break_o
);

  localparam int OSW = $clog2(OS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [OSW-1:0] C_HALF = OSW'(OS / 2 - 1);
  localparam logic [OSW-1:0] C_LAST = OSW'(OS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
`ifdef UART_RX_BREAK_DET_EN
    , S_BRK  = 3'd6
`endif
  } state_t;

  // Parity check: the received parity bit must equal data XOR plus the odd flag.
  function automatic logic f_parity_err(input logic sample, input logic xor_data, input logic odd);
    return sample != (xor_data ^ odd);
  endfunction

  logic             r_sync1, r_sync2, r_sync3;
  logic [DIV_W-1:0] r_div_cnt;
  state_t           r_state, w_state_nx;
  logic [OSW-1:0]   r_os_cnt, w_os_nx;
  logic [2:0]       r_bit_cnt, w_bit_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic             r_xor, w_xor_nx;
  logic             r_perr, w_perr_nx;
  logic             r_ferr, w_ferr_nx;
  logic [1:0]       r_cfg_bits, w_cfg_bits_nx;
  logic             r_cfg_pen, w_cfg_pen_nx;
  logic             r_cfg_odd, w_cfg_odd_nx;
  logic             r_cfg_stop2, w_cfg_stop2_nx;
  logic             r_push, w_push_nx;
  logic [9:0]       r_push_word;
  logic             w_div_clr, w_tick, w_fall;
`ifdef UART_RX_BREAK_DET_EN
  logic             r_par_bit, w_par_bit_nx;
  logic             r_brk, w_brk_nx;
`endif

  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ovr;
  logic             w_pop, w_full, w_wr;

  assign w_fall = r_sync3 & ~r_sync2;
  assign w_tick = rx_enable_i & (r_div_cnt == clk_div_i);

  // Two-flop synchroniser on rx_i plus a third copy for falling-edge detection.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Sample-tick divider: realigned on start edges, parked at 0 while disabled.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_div_cnt <= '0;
    end else if (!rx_enable_i || w_div_clr || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Next-state and datapath logic of the receive FSM.
  always_comb begin
    w_state_nx     = r_state;
    w_os_nx        = r_os_cnt;
    w_bit_nx       = r_bit_cnt;
    w_shift_nx     = r_shift;
    w_xor_nx       = r_xor;
    w_perr_nx      = r_perr;
    w_ferr_nx      = r_ferr;
    w_cfg_bits_nx  = r_cfg_bits;
    w_cfg_pen_nx   = r_cfg_pen;
    w_cfg_odd_nx   = r_cfg_odd;
    w_cfg_stop2_nx = r_cfg_stop2;
    w_push_nx      = 1'b0;
    w_div_clr      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    w_par_bit_nx   = r_par_bit;
    w_brk_nx       = 1'b0;
`endif
    if (!rx_enable_i) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_cfg_bits_nx  = data_bits_i;
            w_cfg_pen_nx   = parity_en_i;
            w_cfg_odd_nx   = parity_odd_i;
            w_cfg_stop2_nx = stop2_i;
            w_os_nx        = '0;
            w_bit_nx       = 3'd0;
            w_shift_nx     = 8'd0;
            w_xor_nx       = 1'b0;
            w_perr_nx      = 1'b0;
            w_ferr_nx      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            w_par_bit_nx   = 1'b0;
`endif
            w_div_clr      = 1'b1;
            w_state_nx     = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        S_START: begin
          if (w_tick && (r_os_cnt == C_HALF)) begin
            w_os_nx    = '0;
            w_state_nx = r_sync2 ? S_IDLE : S_DATA;
          end else if (w_tick) begin
            w_os_nx = r_os_cnt + OSW'(1);
          end else begin
            w_os_nx = r_os_cnt;
          end
        end
        S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
          if (w_tick && (r_os_cnt == C_LAST)) begin
            w_os_nx = '0;
            if (r_state == S_DATA) begin
              w_shift_nx[r_bit_cnt] = r_sync2;
              w_xor_nx              = r_xor ^ r_sync2;
              if (r_bit_cnt == {1'b1, r_cfg_bits}) begin
                w_bit_nx   = 3'd0;
                w_state_nx = r_cfg_pen ? S_PARITY : S_STOP1;
              end else begin
                w_bit_nx = r_bit_cnt + 3'd1;
              end
            end else if (r_state == S_PARITY) begin
              w_perr_nx    = f_parity_err(r_sync2, r_xor, r_cfg_odd);
`ifdef UART_RX_BREAK_DET_EN
              w_par_bit_nx = r_sync2;
`endif
              w_state_nx   = S_STOP1;
            end else if (r_state == S_STOP1) begin
              w_ferr_nx = ~r_sync2;
`ifdef UART_RX_BREAK_DET_EN
              if ((r_shift == 8'd0) && !r_par_bit && !r_sync2) begin
                w_push_nx  = 1'b1;
                w_brk_nx   = 1'b1;
                w_state_nx = S_BRK;
              end else
`endif
              if (r_cfg_stop2) begin
                w_state_nx = S_STOP2;
              end else begin
                w_push_nx  = 1'b1;
                w_state_nx = S_IDLE;
              end
            end else begin
              w_ferr_nx  = r_ferr | ~r_sync2;
              w_push_nx  = 1'b1;
              w_state_nx = S_IDLE;
            end
          end else if (w_tick) begin
            w_os_nx = r_os_cnt + OSW'(1);
          end else begin
            w_os_nx = r_os_cnt;
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        S_BRK: begin
          if (r_sync2) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_BRK;
          end
        end
`endif
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // FSM state and frame datapath registers; the push word is captured every cycle.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_xor       <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_cfg_bits  <= 2'd0;
      r_cfg_pen   <= 1'b0;
      r_cfg_odd   <= 1'b0;
      r_cfg_stop2 <= 1'b0;
      r_push      <= 1'b0;
      r_push_word <= 10'd0;
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit   <= 1'b0;
      r_brk       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_os_cnt    <= w_os_nx;
      r_bit_cnt   <= w_bit_nx;
      r_shift     <= w_shift_nx;
      r_xor       <= w_xor_nx;
      r_perr      <= w_perr_nx;
      r_ferr      <= w_ferr_nx;
      r_cfg_bits  <= w_cfg_bits_nx;
      r_cfg_pen   <= w_cfg_pen_nx;
      r_cfg_odd   <= w_cfg_odd_nx;
      r_cfg_stop2 <= w_cfg_stop2_nx;
      r_push      <= w_push_nx;
      r_push_word <= {w_ferr_nx, w_perr_nx, w_shift_nx};
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit   <= w_par_bit_nx;
      r_brk       <= w_brk_nx;
`endif
    end
  end

  assign w_pop  = (r_level != LW'(0)) & rx_ready_i;
  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_wr   = r_push & (~w_full | w_pop);

  // Receive FIFO: a push while full is dropped unless a pop frees the slot.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 10'd0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_push_word;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      r_ovr <= r_push & w_full & ~w_pop;
    end
  end

  assign rx_valid_o   = (r_level != LW'(0));
  assign rx_data_o    = rx_valid_o ? r_mem[r_rd_ptr][7:0] : 8'd0;
  assign rx_perr_o    = rx_valid_o & r_mem[r_rd_ptr][8];
  assign rx_ferr_o    = rx_valid_o & r_mem[r_rd_ptr][9];
  assign fifo_level_o = r_level;
  assign rx_overrun_o = r_ovr;
  assign rx_busy_o    = (r_state != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign rx_break_o   = r_brk;
`else
  assign rx_break_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os (clk_div=3, OS=16 -> 64 clk per bit).
module tb_uart_rx_os;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        rx_enable_i = 1'b0;
  logic [31:0] clk_div_i = 32'd3;
  logic [1:0]  data_bits_i = 2'b11;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop2_i = 1'b0;
  logic        rx_i = 1'b1;
  logic [7:0]  rx_data_o;
  logic        rx_perr_o, rx_ferr_o, rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic [3:0]  fifo_level_o;
  logic        rx_overrun_o, rx_busy_o, rx_break_o;

  int errors = 0;
  int checks = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;

  uart_rx_os #(.OS(16), .FIFO_DEPTH(8), .DIV_W(32)) dut (
    .clk(clk), .rstn_i(rstn_i), .rx_enable_i(rx_enable_i), .clk_div_i(clk_div_i),
    .data_bits_i(data_bits_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
    .stop2_i(stop2_i), .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o),
    .rx_ferr_o(rx_ferr_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .fifo_level_o(fifo_level_o), .rx_overrun_o(rx_overrun_o), .rx_busy_o(rx_busy_o),
    .rx_break_o(rx_break_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_overrun_o) ovr_cnt++;
    if (rx_break_o) brk_cnt++;
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx_i = v;
    repeat (64) @(negedge clk);
  endtask

  // One frame: start, nb data bits LSB first, optional parity, first stop, optional second stop.
  task automatic send(input logic [7:0] d, input int nb, input logic pen, input logic pbit,
                      input logic s1, input int nstop);
    bit_time(1'b0);
    for (int i = 0; i < nb; i++) bit_time(d[i]);
    if (pen) bit_time(pbit);
    bit_time(s1);
    if (nstop == 2) bit_time(1'b1);
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] b, input logic pen, input logic odd, input logic s2);
    data_bits_i = b; parity_en_i = pen; parity_odd_i = odd; stop2_i = s2;
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_level", 32'(fifo_level_o), 32'd0);
    chk("rst_busy", 32'(rx_busy_o), 32'd0);
    chk("rst_data", 32'(rx_data_o), 32'd0);
    chk("rst_ovr", 32'(rx_overrun_o), 32'd0);
    rstn_i = 1'b1;
    rx_enable_i = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("8n1_valid", 32'(rx_valid_o), 32'd1);
    chk("8n1_data", 32'(rx_data_o), 32'hA5);
    chk("8n1_perr", 32'(rx_perr_o), 32'd0);
    chk("8n1_ferr", 32'(rx_ferr_o), 32'd0);
    chk("8n1_level", 32'(fifo_level_o), 32'd1);
    pop();
    chk("8n1_pop_level", 32'(fifo_level_o), 32'd0);
    chk("8n1_pop_valid", 32'(rx_valid_o), 32'd0);

    // 7E2 0x3C: four ones -> even parity bit should be 0, send 1
    cfg(2'b10, 1'b1, 1'b0, 1'b1);
    send(8'h3C, 7, 1'b1, 1'b1, 1'b1, 2);
    chk("7e2_data", 32'(rx_data_o), 32'h3C);
    chk("7e2_perr", 32'(rx_perr_o), 32'd1);
    chk("7e2_ferr", 32'(rx_ferr_o), 32'd0);
    pop();

    // 5O1 0x15: three ones -> odd parity bit 0 (correct), stop bit low
    cfg(2'b00, 1'b1, 1'b1, 1'b0);
    send(8'h15, 5, 1'b1, 1'b0, 1'b0, 1);
    chk("5o1_data", 32'(rx_data_o), 32'h15);
    chk("5o1_perr", 32'(rx_perr_o), 32'd0);
    chk("5o1_ferr", 32'(rx_ferr_o), 32'd1);
    pop();
    chk("5o1_empty_data", 32'(rx_data_o), 32'd0);

    // Glitch shorter than half a bit
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_hi", 32'(rx_busy_o), 32'd1);
    repeat (10) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy_lo", 32'(rx_busy_o), 32'd0);
    chk("glitch_level", 32'(fifo_level_o), 32'd0);

    // Overrun: nine frames with no pops
    base = ovr_cnt;
    for (int i = 0; i < 9; i++) send(8'(i), 8, 1'b0, 1'b0, 1'b1, 1);
    chk("ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    chk("ovr_level", 32'(fifo_level_o), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("ovr_order", 32'(rx_data_o), 32'(i));
      pop();
    end
    chk("ovr_drained", 32'(fifo_level_o), 32'd0);

    // Full FIFO with a pop in the push cycle: no overrun
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b1, 1);
    chk("full_level", 32'(fifo_level_o), 32'd8);
    base = ovr_cnt;
    fork
      send(8'h18, 8, 1'b0, 1'b0, 1'b1, 1);
      begin
        n = 0;
        while (!rx_busy_o && n < 200) begin @(negedge clk); n++; end
        chk("sim_busy_rise", 32'(rx_busy_o), 32'd1);
        n = 0;
        while (rx_busy_o && n < 1000) begin @(negedge clk); n++; end
        chk("sim_busy_fall", 32'(rx_busy_o), 32'd0);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
      end
    join
    chk("sim_no_ovr", 32'(ovr_cnt - base), 32'd0);
    chk("sim_level", 32'(fifo_level_o), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("sim_order", 32'(rx_data_o), 32'h11 + 32'(i));
      pop();
    end

    // Enable drop mid-frame
    send(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1);
    fork
      send(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1);
      begin
        repeat (192) @(negedge clk);
        chk("en_busy_mid", 32'(rx_busy_o), 32'd1);
        rx_enable_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("en_busy_off", 32'(rx_busy_o), 32'd0);
      end
    join
    chk("en_level", 32'(fifo_level_o), 32'd1);
    chk("en_head", 32'(rx_data_o), 32'h5A);
    rx_enable_i = 1'b1;
    repeat (16) @(negedge clk);
    send(8'h96, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("en_level2", 32'(fifo_level_o), 32'd2);
    pop();
    chk("en_new", 32'(rx_data_o), 32'h96);
    pop();

`ifdef UART_RX_BREAK_DET_EN
    base = brk_cnt;
    rx_i = 1'b0;
    repeat (1920) @(negedge clk);
    chk("brk_busy", 32'(rx_busy_o), 32'd1);
    chk("brk_level", 32'(fifo_level_o), 32'd1);
    chk("brk_data", 32'(rx_data_o), 32'd0);
    chk("brk_ferr", 32'(rx_ferr_o), 32'd1);
    chk("brk_pulses", 32'(brk_cnt - base), 32'd1);
    rx_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("brk_exit", 32'(rx_busy_o), 32'd0);
    pop();
`else
    chk("no_break", 32'(brk_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
